// File: rtl/addsub_rr_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | addsub_rr_sched : round-robin scheduler sharing one ripple add/sub |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module addsub_rr_sched #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   sub_i,
  input  logic [NREQ*N-1:0] a_i,
  input  logic [NREQ*N-1:0] b_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   done_o,
  output logic [N-1:0]      result_o,
  output logic              ovf_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [PW:0] C_NREQ = (PW+1)'(NREQ);

  state_e            state_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     win_q;
  logic [N-1:0]      opa_q;
  logic [N-1:0]      opb_q;
  logic              ops_q;
  logic [NREQ-1:0]   done_q;
  logic [N-1:0]      result_q;
  logic              ovf_q;
  logic              busy_q;

  logic [PW-1:0]     ptr_d;
  logic [PW-1:0]     w_base;
  logic [NREQ-1:0]   w_elig;
  logic [PW:0]       w_idx;
  logic              w_found;
  logic [PW-1:0]     w_pick;
  logic [N-1:0]      w_sel_a;
  logic [N-1:0]      w_sel_b;
  logic              w_sel_s;
  logic [N-1:0]      w_bx;
  logic [N-1:0]      w_sum;
  logic              w_c;
  logic              w_cmsb;
  logic              w_ovf;

  assign ptr_d  = (win_q == PW'(NREQ-1)) ? '0 : win_q + 1'b1;
  assign w_base = (state_q == S_DONE) ? ptr_d : ptr_q;

  // The completing requester is masked so a still-high req is not re-served at once.
  always_comb begin
    w_elig = '0;
    if (state_q == S_IDLE)      w_elig = req_i;
    else if (state_q == S_DONE) w_elig = req_i & ~done_q;
  end

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int off = 0; off < NREQ; off++) begin
      w_idx = {1'b0, w_base} + (PW+1)'(off);
      if (w_idx >= C_NREQ) w_idx = w_idx - C_NREQ;
      if (!w_found && w_elig[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    w_sel_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == PW'(i)) begin
        w_sel_a = a_i[i*N +: N];
        w_sel_b = b_i[i*N +: N];
        w_sel_s = sub_i[i];
      end
    end
  end

  // Grant is visible in the arbitration cycle itself; reset forces it low at once.
  assign gnt_o = (w_found && !rst) ? (NREQ'(1) << w_pick) : '0;

  // Shared ripple add/sub; overflow is carry-into-MSB xor carry-out.
  always_comb begin
    w_bx   = opb_q ^ {N{ops_q}};
    w_c    = ops_q;
    w_cmsb = 1'b0;
    w_sum  = '0;
    for (int i = 0; i < N; i++) begin
      if (i == N-1) w_cmsb = w_c;
      w_sum[i] = opa_q[i] ^ w_bx[i] ^ w_c;
      w_c      = (opa_q[i] & w_bx[i]) | (opa_q[i] & w_c) | (w_bx[i] & w_c);
    end
    w_ovf = w_cmsb ^ w_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      ops_q    <= 1'b0;
      done_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (w_found) begin
            opa_q   <= w_sel_a;
            opb_q   <= w_sel_b;
            ops_q   <= w_sel_s;
            win_q   <= w_pick;
            state_q <= S_EXEC;
            busy_q  <= 1'b1;
          end
        end
        S_EXEC: begin
          result_q <= w_sum;
          ovf_q    <= w_ovf;
          done_q   <= NREQ'(1) << win_q;
          state_q  <= S_DONE;
          busy_q   <= 1'b1;
        end
        S_DONE: begin
          ptr_q <= ptr_d;
          if (w_found) begin
            opa_q   <= w_sel_a;
            opb_q   <= w_sel_b;
            ops_q   <= w_sel_s;
            win_q   <= w_pick;
            state_q <= S_EXEC;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign done_o   = done_q;
  assign result_o = result_q;
  assign ovf_o    = ovf_q;
  assign busy_o   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub_rr_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_addsub_rr_sched : scoreboard bench for the add/sub scheduler    |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module tb_addsub_rr_sched;

  localparam int N    = 32;
  localparam int NREQ = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   sub;
  logic [NREQ*N-1:0] a;
  logic [NREQ*N-1:0] b;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [N-1:0]      result;
  logic              ovf;
  logic              busy;

  addsub_rr_sched #(.N(N), .NREQ(NREQ)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .sub_i    (sub),
    .a_i      (a),
    .b_i      (b),
    .gnt_o    (gnt),
    .done_o   (done),
    .result_o (result),
    .ovf_o    (ovf),
    .busy_o   (busy)
  );

  typedef struct {
    int         idx;
    logic [N-1:0] res;
    logic       o;
    int         due;
  } exp_t;

  exp_t  sb[$];
  int    grant_log[$];
  int    done_log[$];
  int    mode [NREQ];   // 0: drop at done, 1: keep requesting with new operands, 2: manual
  int    cyc;
  int    checks;
  int    failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N:0] model(input logic [N-1:0] av, input logic [N-1:0] bv, input logic s);
    logic [N-1:0] bx;
    logic [N-1:0] r;
    logic         o;
    bx = s ? ~bv : bv;
    r  = av + bx + {{(N-1){1'b0}}, s};
    o  = (av[N-1] == bx[N-1]) && (r[N-1] != av[N-1]);
    return {o, r};
  endfunction

  // Scoreboard: push at grant, pop and compare at done.
  exp_t        mon_e;
  logic [N:0]  mon_m;
  int          mon_gi;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done != '0) begin
          check("done_onehot", 64'($onehot(done)), 64'd1);
          done_log.push_back(cyc);
          if (sb.size() == 0) begin
            check("done_unexpected", 64'(done), 64'd0);
          end else begin
            mon_e = sb.pop_front();
            check("done_who", 64'(done), 64'(NREQ'(1) << mon_e.idx));
            check("result", 64'(result), 64'(mon_e.res));
            check("ovf", 64'(ovf), 64'(mon_e.o));
            check("done_cycle", 64'(cyc), 64'(mon_e.due));
          end
        end
        if (gnt != '0) begin
          check("gnt_onehot", 64'($onehot(gnt)), 64'd1);
          mon_gi = 0;
          for (int i = 0; i < NREQ; i++) if (gnt[i]) mon_gi = i;
          mon_m = model(a[mon_gi*N +: N], b[mon_gi*N +: N], sub[mon_gi]);
          mon_e.idx = mon_gi;
          mon_e.res = mon_m[N-1:0];
          mon_e.o   = mon_m[N];
          mon_e.due = cyc + 2;
          sb.push_back(mon_e);
          grant_log.push_back(mon_gi);
        end
        for (int i = 0; i < NREQ; i++) begin
          if (done[i]) begin
            if (mode[i] == 0) begin
              req[i] = 1'b0;
            end else if (mode[i] == 1) begin
              a[i*N +: N] = $urandom;
              b[i*N +: N] = $urandom;
              sub[i]      = 1'($urandom_range(0, 1));
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int i, input logic s, input logic [N-1:0] av, input logic [N-1:0] bv);
    a[i*N +: N] = av;
    b[i*N +: N] = bv;
    sub[i]      = s;
    req[i]      = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && req == '0 && !busy && gnt == '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 64'd0, 64'd1);
    step();
  endtask

  int nbusy;

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    req = '0;
    sub = '0;
    a   = '0;
    b   = '0;
    for (int i = 0; i < NREQ; i++) mode[i] = 0;
    step();
    step();
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    step();

    // Single add with explicit latency
    post(0, 1'b0, 32'h0000_0005, 32'h0000_0003);
    @(negedge clk);
    check("t1_gnt", 64'(gnt), 64'h1);
    @(negedge clk);
    check("t1_done_early", 64'(done), 64'h0);
    check("t1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("t1_done", 64'(done), 64'h1);
    check("t1_result", 64'(result), 64'h8);
    check("t1_ovf", 64'(ovf), 64'd0);
    wait_idle(20);

    // Overflow cases
    post(1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_idle(20);
    check("ovf_add_res", 64'(result), 64'h8000_0000);
    check("ovf_add_flag", 64'(ovf), 64'd1);
    post(1, 1'b1, 32'h8000_0000, 32'h0000_0001);
    wait_idle(20);
    check("ovf_sub_res", 64'(result), 64'h7FFF_FFFF);
    check("ovf_sub_flag", 64'(ovf), 64'd1);
    post(1, 1'b1, 32'h0000_0003, 32'h0000_0005);
    wait_idle(20);
    check("neg_sub_res", 64'(result), 64'hFFFF_FFFE);
    check("neg_sub_flag", 64'(ovf), 64'd0);

    // All four at once: ptr is back at 0 after requester 1 -> wraps? ptr=2 here, so reset ptr first
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
    grant_log.delete();
    done_log.delete();
    post(0, 1'b0, 32'h1234_5678, 32'h1111_1111);
    post(1, 1'b1, 32'h0000_0010, 32'h0000_0020);
    post(2, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    post(3, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF);
    nbusy = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    check("all4_busy_cycles", 64'(nbusy), 64'd8);
    wait_idle(20);
    check("all4_grants", 64'(grant_log.size()), 64'd4);
    check("all4_dones", 64'(done_log.size()), 64'd4);
    if (grant_log.size() == 4 && done_log.size() == 4) begin
      for (int i = 0; i < 4; i++) check("all4_order", 64'(grant_log[i]), 64'(i));
      for (int i = 0; i < 3; i++) check("all4_spacing", 64'(done_log[i+1] - done_log[i]), 64'd2);
    end

    // Fairness between requesters 0 and 2 (ptr is 0 after serving 3)
    grant_log.delete();
    mode[0] = 1;
    mode[2] = 1;
    post(0, 1'b0, 32'h0000_0100, 32'h0000_0200);
    post(2, 1'b1, 32'h0000_0300, 32'h0000_0400);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (grant_log.size() >= 6) break;
    end
    step();
    mode[0] = 0;
    mode[2] = 0;
    wait_idle(40);
    check("fair_count", 64'(grant_log.size() >= 6), 64'd1);
    if (grant_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) check("fair_order", 64'(grant_log[i]), (i % 2 == 0) ? 64'd0 : 64'd2);
    end

    // Masking: requester 2 holds req one extra cycle after done
    mode[2] = 2;
    post(2, 1'b0, 32'h0000_00A0, 32'h0000_000B);
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        if (done[2]) begin
          seen = 1'b1;
          break;
        end
      end
      check("mask_done_seen", 64'(seen), 64'd1);
    end
    check("mask_no_regrant", 64'(gnt), 64'h0);
    @(negedge clk);
    check("mask_regrant", 64'(gnt), 64'h4);
    step();
    req[2] = 1'b0;
    mode[2] = 0;
    wait_idle(20);

    // Reset during EXEC; ptr is 3 here, so requester 0 wins
    post(0, 1'b0, 32'h0000_0042, 32'h0000_0001);
    @(negedge clk);
    check("rst_abort_gnt", 64'(gnt), 64'h1);
    step();
    rst = 1'b1;
    #1;
    check("rst_mid_gnt", 64'(gnt), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_result", 64'(result), 64'd0);
    check("rst_mid_ovf", 64'(ovf), 64'd0);
    req[0] = 1'b0;
    sb.delete();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("rst_no_done", 64'(done), 64'd0);
    end
    step();
    rst = 1'b0;
    grant_log.delete();
    post(1, 1'b0, 32'h0000_0007, 32'h0000_0008);
    post(3, 1'b1, 32'h0000_0009, 32'h0000_0002);
    wait_idle(20);
    check("post_rst_grants", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      check("post_rst_first", 64'(grant_log[0]), 64'd1);
      check("post_rst_second", 64'(grant_log[1]), 64'd3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/addsub_rr_sched.md
Name: addsub_rr_sched

Overview:
- Round-robin scheduler that shares one N-bit ripple add/sub datapath among NREQ requesters.
  - Add/sub semantics: subtract = invert B, carry-in 1; overflow = carry-into-MSB XOR carry-out.
- Each requester posts operands and an op select, then holds them until it receives a one-cycle done pulse carrying the result and signed overflow.
- Sits between the ALU issue logic, address-generation units and the single add/sub slice, so only one adder is instantiated.

Parameters:
- N, 32, operand/result width in bits (>=2).
- NREQ, 4, number of requesters (2..8).
- PW, $clog2(NREQ), width of the round-robin pointer (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- req  input  NREQ  level request per requester; held until the matching done
- sub  input  NREQ  per-requester op: 0 = A+B, 1 = A-B
- a  input  NREQ*N  flattened A operands; requester i at bits [i*N +: N]
- b  input  NREQ*N  flattened B operands, same packing as a
- gnt  output  NREQ  one-hot, high in the cycle the winner's operands are latched
- done  output  NREQ  one-hot single-cycle completion pulse
- result  output  N  sum/difference; valid only while done != 0
- ovf  output  1  signed overflow of result; valid only while done != 0
- busy  output  1  high in EXEC and DONE

Behaviour:
- Reset (async, immediate): state = IDLE, ptr = 0, gnt = 0, done = 0, result = 0, ovf = 0, busy = 0.
  - Any in-flight operation is discarded; no done pulse is ever issued for it.
- States:
  - IDLE: if (req & ~mask) != 0, pick the winner, latch a/b/sub of the winner into opA/opB/opS, pulse gnt[winner], go to EXEC; otherwise stay.
  - EXEC: the shared datapath computes from the latched operands (a full cycle for ripple settle). Register the sum into result and the overflow into ovf, go to DONE.
  - DONE: done[winner] = 1 for exactly this cycle.
    - ptr <= (winner + 1) mod NREQ.
    - If another eligible request exists, arbitrate as in IDLE (gnt pulse this cycle) and go to EXEC; else go to IDLE.
- Arbitration: the first requester found scanning from ptr upward with wrap (ptr, ptr+1, ..., NREQ-1, 0, ...).
- Mask: in DONE the just-completing requester's req is masked; in IDLE mask = 0. The requester must drop req in the cycle after done; if it keeps req high it is treated as a new request.
- Latency: req seen at edge k in IDLE gives gnt high in cycle k, done high in cycle k+2. Back-to-back throughput is one op per 2 cycles.
- Operands are latched at grant. Requester a/b/sub may change after gnt without effect, but the handshake rule remains "hold until done".
- Arithmetic, two's complement, width N, carry-out discarded:
  - Subtract: result = opA + ~opB + 1.
  - ovf = (opA[N-1] == Bx[N-1]) && (result[N-1] != opA[N-1]), where Bx = opB ^ {N{opS}}; equivalent to carry-into-MSB XOR carry-out.
- result and ovf keep their last value outside DONE.
- gnt and done are never asserted for more than one requester. A requester that deasserts req before grant is simply not served; no error flag is raised.
- Dropping req after grant does not cancel the operation.

Test Plan:
- Single add: req[0], a0=0x00000005, b0=0x00000003, sub=0 -> gnt=4'b0001 at cycle k, done=4'b0001 at k+2, result=0x00000008, ovf=0.
- Overflow: req[1], a1=0x7FFFFFFF, b1=0x00000001 add -> result=0x80000000, ovf=1. Then a1=0x80000000, b1=0x00000001 sub -> result=0x7FFFFFFF, ovf=1. Then 0x00000003-0x00000005 -> 0xFFFFFFFE, ovf=0.
- All four requests asserted together from reset (ptr=0), each dropped after its done -> grant order 0,1,2,3, done pulses 2 cycles apart, busy continuously high until last done, then IDLE.
- Fairness: req[0] and req[2] held continuously, each re-asserting immediately after its done -> grants alternate 0,2,0,2; requester 0 is never served twice in a row.
- Reset mid-operation: assert rst during EXEC -> gnt/done/busy/result/ovf go 0 immediately with no clock edge, no done for the aborted op. After release with req[3] held, requester 3 is granted with ptr=0 order.
- Masking: requester 2 keeps req high one extra cycle after done while no one else requests -> no re-grant in the DONE cycle. Re-granted from IDLE on the next cycle as a new request.
